serial_adder_ctrl: RTL and testbench

Bit-serial WIDTH-bit adder controller. It sequences one shared 1-bit full-adder datapath across the operand bits, one bit per clock, LSB first. The full adder is built from two `half_adder` instances and an OR of their carries. The block accepts an operand pair on a start pulse, runs WIDTH add cycles with a registered carry, and then presents the registered sum and carry-out with a one-cycle done pulse. It is the area-minimal alternative to a WIDTH-bit ripple adder in the combinational library.

---
 rtl/serial_adder_ctrl.sv | 95 +++++++++
 tb/tb_serial_adder_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, one shared full adder stepped LSB first.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  // Encoding chosen so busy and done are straight flop outputs.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             h0_s, h0_c, h1_s, h1_c, fa_c;
  half_adder u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]), .s_o(h0_s), .c_o(h0_c));
  half_adder u_ha1 (.a_i(h0_s),   .b_i(c_q),    .s_o(h1_s), .c_o(h1_c));
  assign fa_c = h0_c | h1_c;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == IDLE && start) begin
      a_d     = a;
      b_d     = b;
      s_d     = '0;
      c_d     = 1'b0;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      s_d   = {h1_s, s_q[WIDTH-1:1]};
      c_d   = fa_c;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        sum_d   = s_d;
        cout_d  = fa_c;
        state_d = DONE;
      end
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign busy      = state_q[0];
  assign done      = state_q[1];
  assign sum       = sum_q;
  assign carry_out = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for WIDTH=8 and WIDTH=4 serial adders.
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st8 = 1'b0, st4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       busy8, done8, cout8, busy4, done4, cout4;
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  int checks = 0, errors = 0, cyc = 0;
  int blen8 = 0, blen4 = 0, last8 = -1;
  bit pd8 = 0, pd4 = 0, b2b = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
  );
  serial_adder_ctrl #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitors: pop the scoreboard whenever a done pulse appears.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      blen8 = 0;
      pd8 = 0;
    end else begin
      if (busy8) blen8++;
      if (done8) begin
        chk("busy_len8", blen8, 8);
        chk("done_excl8", {busy8, pd8}, 2'b00);
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL stray_done8: got sum=%0h cout=%0b want no done", sum8, cout8);
        end else chk("result8", {cout8, sum8}, q8.pop_front());
        if (b2b && last8 >= 0) chk("spacing8", cyc - last8, 10);
        if (b2b) last8 = cyc;
        blen8 = 0;
      end else if (!busy8) blen8 = 0;
      pd8 = done8;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      blen4 = 0;
      pd4 = 0;
    end else begin
      if (busy4) blen4++;
      if (done4) begin
        chk("busy_len4", blen4, 4);
        chk("done_excl4", {busy4, pd4}, 2'b00);
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL stray_done4: got sum=%0h cout=%0b want no done", sum4, cout4);
        end else chk("result4", {cout4, sum4}, q4.pop_front());
        blen4 = 0;
      end else if (!busy4) blen4 = 0;
      pd4 = done4;
    end
  end

  task automatic start_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          input logic [8:0] exp, input bit push);
    @(posedge clk); #1;
    if (w == 8) begin
      st8 = 1'b1; a8 = av; b8 = bv;
      if (push) q8.push_back(exp);
    end else begin
      st4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0];
      if (push) q4.push_back(exp[4:0]);
    end
    @(posedge clk); #1;
    st8 = 1'b0; st4 = 1'b0;
  endtask

  // Counts negedges from just after the start edge until done is seen.
  task automatic wait_done(input int w, input int lat);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = (w == 8) ? done8 : done4;
    end
    checks++;
    if (!seen || (lat > 0 && n != lat)) begin
      errors++;
      $display("FAIL latency_w%0d: got %0d cycles (seen=%0b) want %0d", w, n, seen, lat);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p, k, off;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_out8", {cout8, sum8}, 0);
    chk("rst_out4", {busy4, done4, cout4, sum4}, 0);

    start_op(8, 8'hFF, 8'h01, 9'h100, 1);
    wait_done(8, 9);
    start_op(8, 8'hA5, 8'h5A, 9'h0FF, 1);
    wait_done(8, 9);

    // start re-raised with other operands throughout RUN and DONE
    start_op(8, 8'h10, 8'h20, 9'h030, 1);
    st8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    wait_done(8, 9);
    @(posedge clk); #1 st8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("idle_after_ignored", {busy8, done8}, 0);

    start_op(8, 8'h80, 8'h80, 9'h000, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy8, 0);
    chk("midrst_out", {cout8, sum8}, 0);
    repeat (15) @(negedge clk);
    start_op(8, 8'h80, 8'h80, 9'h100, 1);
    wait_done(8, 9);

    b2b = 1;
    last8 = -1;
    @(posedge clk); #1;
    st8 = 1'b1; a8 = 8'd3; b8 = 8'd4; q8.push_back(9'h007);
    @(posedge clk); #1;
    a8 = 8'd200; b8 = 8'd100; q8.push_back(9'h12C);
    wait_done(8, 9);
    repeat (3) @(negedge clk);
    chk("hold_between", {cout8, sum8}, 9'h007);
    wait_done(8, 0);
    @(posedge clk); #1 st8 = 1'b0;
    b2b = 0;
    repeat (3) @(negedge clk);

    start_op(4, 8'h0F, 8'h0F, 9'h01E, 1);
    wait_done(4, 5);
    k = 8'($urandom_range(0, 127) * 2 + 1);
    off = 8'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) begin
      p = 8'(i) * k + off;
      start_op(4, {4'h0, p[7:4]}, {4'h0, p[3:0]}, 9'(p[7:4]) + 9'(p[3:0]), 1);
      wait_done(4, 5);
    end
    repeat (4) @(negedge clk);
    chk("sb_empty", q8.size() + q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
